// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - state encodings, stall vectors and bus width for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] ZERO_WORD = '0;

  // Stall bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - request/stall/flush bundle between core and pipe_ctrl
// Carries stall_cycles only when PIPE_STALL_CNT_EN is defined.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic              stallreq_id;
  logic              stallreq_ex;
  logic              mc_ready;
  logic              flush_req;
  logic [ADDR_W-1:0] flush_pc;
  logic [5:0]        stall;
  logic              mc_start;
  logic              mc_annul;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              mc_err;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  modport master (
    input  stallreq_id, stallreq_ex, mc_ready, flush_req, flush_pc,
    output stall, mc_start, mc_annul, flush, new_pc, mc_err
`ifdef PIPE_STALL_CNT_EN
    , output stall_cycles
`endif
  );

  modport slave (
    output stallreq_id, stallreq_ex, mc_ready, flush_req, flush_pc,
    input  stall, mc_start, mc_annul, flush, new_pc, mc_err
`ifdef PIPE_STALL_CNT_EN
    , input stall_cycles
`endif
  );

endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall merge, multi-cycle handshake and flush sequencing
// Optional stall_cycles counter enabled by PIPE_STALL_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT   = 64,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master io
);

  localparam int WAIT_W  = $clog2(MC_TIMEOUT);
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MC_TIMEOUT - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              start_q, start_d;
  logic              annul_q, annul_d;
  logic              err_q, err_d;
  logic [5:0]        stall_d;
  logic              flush_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      pc_q        <= ZERO_WORD;
      start_q     <= 1'b0;
      annul_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pc_q        <= pc_d;
      start_q     <= start_d;
      annul_q     <= annul_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_d        = pc_q;
    start_d     = 1'b0;
    annul_d     = 1'b0;
    err_d       = err_q;
    stall_d     = STALL_NONE;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d  = '0;
        flush_cnt_d = '0;
        if (io.flush_req) begin
          pc_d    = io.flush_pc;
          state_d = ST_FLUSH;
        end else if (io.stallreq_ex) begin
          stall_d = STALL_EX;
          start_d = 1'b1;
          state_d = ST_MC_WAIT;
        end else if (io.stallreq_id) begin
          stall_d = STALL_ID;
        end
      end
      ST_MC_WAIT: begin
        stall_d    = STALL_EX;
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        // A flush discards the in-flight op, so it outranks a same-cycle result.
        if (io.flush_req) begin
          annul_d    = 1'b1;
          pc_d       = io.flush_pc;
          wait_cnt_d = '0;
          state_d    = ST_FLUSH;
        end else if (io.mc_ready) begin
          stall_d    = STALL_NONE;
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          annul_d    = 1'b1;
          err_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        if (flush_cnt_q == FLUSH_LAST) begin
          flush_cnt_d = '0;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Combinational outputs are gated so they fall the instant rst rises.
  assign flush_act   = !rst && (state_q == ST_FLUSH);
  assign io.stall    = rst ? STALL_NONE : stall_d;
  assign io.flush    = flush_act;
  assign io.new_pc   = flush_act ? pc_q : ZERO_WORD;
  assign io.mc_start = start_q;
  assign io.mc_annul = annul_q;
  assign io.mc_err   = err_q;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall_d != STALL_NONE)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign io.stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with per-cycle expected outputs
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 64;
  localparam int TB_FLUSH   = 2;

  typedef struct {
    logic [5:0]  stall;
    logic        start;
    logic        annul;
    logic        flush;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  pipe_ctrl_if bus ();

  exp_t exp_q[$];
  int   checks;
  int   errors;
  logic exp_err;

  pipe_ctrl #(.MC_TIMEOUT(TB_TIMEOUT), .FLUSH_CYCLES(TB_FLUSH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic id, input logic ex, input logic rdy, input logic fr,
                       input logic [31:0] fpc);
    bus.stallreq_id = id;
    bus.stallreq_ex = ex;
    bus.mc_ready    = rdy;
    bus.flush_req   = fr;
    bus.flush_pc    = fpc;
  endtask

  task automatic push(input logic [5:0] e_stall, input logic e_start, input logic e_annul,
                      input logic e_flush, input logic [31:0] e_pc);
    exp_t e;
    e.stall = e_stall;
    e.start = e_start;
    e.annul = e_annul;
    e.flush = e_flush;
    e.pc    = e_pc;
    e.err   = exp_err;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic id, input logic ex, input logic rdy,
                      input logic fr, input logic [31:0] fpc,
                      input logic [5:0] e_stall, input logic e_start, input logic e_annul,
                      input logic e_flush, input logic [31:0] e_pc);
    @(posedge clk);
    #1;
    rst = r;
    if (r) exp_err = 1'b0;
    drive(id, ex, rdy, fr, fpc);
    push(e_stall, e_start, e_annul, e_flush, e_pc);
  endtask

  // Reset rises mid-cycle, well before the sampling edge.
  task automatic rst_mid();
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    exp_err = 1'b0;
    push(STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle(input logic [5:0] e_stall, input logic e_annul);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e_stall, 1'b0, e_annul, 1'b0, 32'h0);
  endtask

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] sc_model = '0;
`endif

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.stall !== e.stall || bus.mc_start !== e.start || bus.mc_annul !== e.annul ||
            bus.flush !== e.flush || bus.new_pc !== e.pc || bus.mc_err !== e.err) begin
          errors++;
          $display("FAIL cycle_out t=%0t: got stall=%b start=%b annul=%b flush=%b pc=%h err=%b, want stall=%b start=%b annul=%b flush=%b pc=%h err=%b",
                   $time, bus.stall, bus.mc_start, bus.mc_annul, bus.flush, bus.new_pc, bus.mc_err,
                   e.stall, e.start, e.annul, e.flush, e.pc, e.err);
        end
`ifdef PIPE_STALL_CNT_EN
        if (rst) sc_model = '0;
        checks++;
        if (bus.stall_cycles !== sc_model) begin
          errors++;
          $display("FAIL stall_cycles t=%0t: got %0d want %0d", $time, bus.stall_cycles, sc_model);
        end
        if (e.stall != STALL_NONE) sc_model = sc_model + 32'd1;
`endif
      end
    end
  end

  initial begin : stimulus
    checks  = 0;
    errors  = 0;
    exp_err = 1'b0;
    rst     = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset state, including requests that must not leak through while in reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234, STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(STALL_NONE, 1'b0);
    idle(STALL_NONE, 1'b0);

    // Load-use: two cycles of id stall
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, STALL_ID, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, STALL_ID, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(STALL_NONE, 1'b0);
    // mc_ready in RUN is ignored
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);

    // Multi-cycle op: request at "cycle 10", ready at "cycle 45"
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, STALL_EX, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, STALL_EX, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 12; i <= 44; i++)
      step(1'b0, (i % 5 == 0), 1'b0, 1'b0, 1'b0, 32'h0, STALL_EX, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);

    // Back-to-back request, then timeout after 64 wait cycles
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, STALL_EX, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, STALL_EX, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i < TB_TIMEOUT; i++)
      idle(STALL_EX, 1'b0);
    exp_err = 1'b1;
    idle(STALL_NONE, 1'b1);
    idle(STALL_NONE, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);

    // Flush during wait; requests during FLUSH are ignored
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, STALL_EX, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, STALL_EX, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, STALL_EX, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hdead_beef, STALL_NONE, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, STALL_NONE, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
    idle(STALL_NONE, 1'b0);

    // Simultaneous flush_req and stallreq_ex in RUN
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, STALL_NONE, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, STALL_NONE, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    // First RUN cycle after FLUSH accepts stallreq_ex
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, STALL_EX, 1'b0, 1'b0, 1'b0, 32'h0);

    // Async reset in the first MC_WAIT cycle; sticky error clears
    rst_mid();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(STALL_NONE, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, STALL_EX, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, STALL_EX, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);

    // Async reset during FLUSH drops flush and new_pc at once
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080, STALL_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, STALL_NONE, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
    rst_mid();
    idle(STALL_NONE, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, STALL_ID, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(STALL_NONE, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core (pc/if/id/ex/mem/wb).
- Merges stall requests from id and ex into one per-stage stall vector.
- Runs the start/ready handshake with the multi-cycle ex unit (divider).
- Sequences exception flushes and supplies the redirect PC.
- Its stall/flush outputs drive every pipeline register, including the mem/wb register, whose hold/clear behaviour it controls.

Parameters:
MC_TIMEOUT, 64, max cycles waiting for mc_ready before annul; must be >=2
FLUSH_CYCLES, 1, cycles flush is held asserted; must be >=1

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
stallreq_id  in  1  load-use hazard from id
stallreq_ex  in  1  ex issuing a multi-cycle op
mc_ready  in  1  multi-cycle unit result valid (1-cycle pulse)
flush_req  in  1  exception taken (1-cycle pulse)
flush_pc  in  32  exception handler address, valid with flush_req
stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold stage
mc_start  out  1  registered 1-cycle start pulse to multi-cycle unit
mc_annul  out  1  registered 1-cycle cancel pulse to multi-cycle unit
flush  out  1  clear if/id/ex/mem/wb pipeline registers
new_pc  out  32  redirect target, valid while flush=1
mc_err  out  1  sticky timeout flag

Behaviour:
- Reset: asynchronous, active-high. State=RUN, wait counter=0, flush counter=0. While rst=1, all outputs are 0, including the combinational stall and new_pc.
- States: RUN, MC_WAIT, FLUSH.
- RUN:
  - flush_req=1 has highest priority. Latch flush_pc, go to FLUSH, stall=0.
  - Else stallreq_ex=1: stall=6'b001111 in the same cycle (combinational), go to MC_WAIT, mc_start=1 in the next cycle (first MC_WAIT cycle only).
  - Else stallreq_id=1: stall=6'b000111 (combinational), stay in RUN.
  - Else stall=0.
- MC_WAIT:
  - stall=6'b001111 and the wait counter increments each cycle.
  - mc_ready=1: stall=0 in that same cycle (combinational release), go to RUN, counter cleared.
  - flush_req=1 (priority over mc_ready): mc_annul=1 next cycle, latch flush_pc, go to FLUSH.
  - Counter reaches MC_TIMEOUT-1 without mc_ready: mc_annul=1 next cycle, mc_err set (sticky until rst), go to RUN.
  - mc_ready while in RUN or FLUSH is ignored.
  - stallreq_id in MC_WAIT is subsumed by 001111.
- FLUSH:
  - flush=1 and new_pc=latched PC for exactly FLUSH_CYCLES cycles, starting the cycle after flush_req. stall=0.
  - flush_req and stallreq_* are ignored while in FLUSH.
  - Exit to RUN.
- Back-to-back: a stallreq_ex in the first RUN cycle after MC_WAIT or FLUSH is accepted normally.
- Counters saturate-free: the wait counter is wide enough for MC_TIMEOUT-1; the flush counter is wide enough for FLUSH_CYCLES.
- Reset mid-operation: reset asserted in any state returns to RUN immediately. No mc_annul is issued; the multi-cycle unit is reset by the same rst.

Optional Feature:
PIPE_STALL_CNT_EN:
- When defined: adds output stall_cycles (32-bit). It increments every cycle in which stall!=0, wraps at 2^32-1 to 0, and resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared defines file holds the state encodings (RUN, MC_WAIT, FLUSH), stall vector constants (STALL_NONE 6'b000000, STALL_ID 6'b000111, STALL_EX 6'b001111) and the 32-bit address bus width. The existing ZeroWord constant is reused.
- Single module; no sub-module. The timeout counter is too small to justify one.

Test Plan:
- Load-use: stallreq_id=1 for 2 cycles from RUN -> stall=6'b000111 in exactly those 2 cycles, mc_start stays 0.
- Multi-cycle op: stallreq_ex at cycle 10, mc_ready at cycle 45 -> stall=6'b001111 in cycles 10..44, mc_start=1 only at cycle 11, stall=0 at 45, mc_err=0.
- Timeout: stallreq_ex, mc_ready never asserted, MC_TIMEOUT=64 -> mc_annul pulses once after 64 MC_WAIT cycles, mc_err=1 and stays 1, state returns to RUN.
- Flush during wait: in MC_WAIT, flush_req with flush_pc=32'h0000_0040 -> next cycle mc_annul=1, flush=1, new_pc=32'h40 for FLUSH_CYCLES cycles, stall=0.
- Simultaneous flush_req and stallreq_ex in RUN -> FLUSH taken, no mc_start, stall=0.
- Async reset in MC_WAIT mid-cycle -> stall, mc_start, flush, new_pc drop to 0 immediately without waiting for a clock edge; RUN after release.
